id_ex_stage_reg: RTL and testbench

ID/EX pipeline register for the 5-stage MIPS datapath. Sits directly downstream of the control unit and register file. Each cycle it captures the decoded control bundle (EX/MEM/WB groups), operands, immediate and register indices. It detects load-use hazards against the instruction currently held, inserts bubbles on load-use or flush, freezes under debug stall, and latches a sticky halt. It also keeps a bubble counter for the debug unit.

---
 rtl/id_ex_stage_reg_if.sv | 74 +++++++
 rtl/id_ex_stage_reg.sv | 128 ++++++++++++
 tb/tb_id_ex_stage_reg.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: ID-side instruction/control inputs and the registered EX-side copies.
// The ID stage and debug unit drive through master; the pipeline register sits on slave.
interface id_ex_stage_reg_if #(
  parameter int unsigned N_BITS      = 32,
  parameter int unsigned N_BITS_REG  = 5,
  parameter int unsigned N_BITS_FUNC = 6,
  parameter int unsigned N_BITS_CNT  = 16
);
  logic                   i_valid;
  logic                   i_stall;
  logic                   i_flush;
  logic                   i_halt;
  logic [1:0]             i_EX_ALUOp;
  logic                   i_EX_ALUSrc;
  logic                   i_EX_regDst;
  logic [1:0]             i_M_branch;
  logic                   i_M_memRead;
  logic                   i_M_memWrite;
  logic                   i_WB_memtoReg;
  logic                   i_WB_regWrite;
  logic [N_BITS-1:0]      i_pc_plus4;
  logic [N_BITS-1:0]      i_rs_data;
  logic [N_BITS-1:0]      i_rt_data;
  logic [N_BITS-1:0]      i_imm_ext;
  logic [N_BITS_REG-1:0]  i_rs;
  logic [N_BITS_REG-1:0]  i_rt;
  logic [N_BITS_REG-1:0]  i_rd;
  logic [N_BITS_FUNC-1:0] i_funct;

  logic                   o_valid;
  logic [1:0]             o_EX_ALUOp;
  logic                   o_EX_ALUSrc;
  logic                   o_EX_regDst;
  logic [1:0]             o_M_branch;
  logic                   o_M_memRead;
  logic                   o_M_memWrite;
  logic                   o_WB_memtoReg;
  logic                   o_WB_regWrite;
  logic [N_BITS-1:0]      o_pc_plus4;
  logic [N_BITS-1:0]      o_rs_data;
  logic [N_BITS-1:0]      o_rt_data;
  logic [N_BITS-1:0]      o_imm_ext;
  logic [N_BITS_REG-1:0]  o_rs;
  logic [N_BITS_REG-1:0]  o_rt;
  logic [N_BITS_REG-1:0]  o_rd;
  logic [N_BITS_FUNC-1:0] o_funct;
  logic                   o_halt;
  logic                   o_load_use_stall;
  logic [N_BITS_CNT-1:0]  o_bubble_count;

  modport master (
    output i_valid, i_stall, i_flush, i_halt,
    output i_EX_ALUOp, i_EX_ALUSrc, i_EX_regDst, i_M_branch, i_M_memRead, i_M_memWrite,
    output i_WB_memtoReg, i_WB_regWrite,
    output i_pc_plus4, i_rs_data, i_rt_data, i_imm_ext, i_rs, i_rt, i_rd, i_funct,
    input  o_valid,
    input  o_EX_ALUOp, o_EX_ALUSrc, o_EX_regDst, o_M_branch, o_M_memRead, o_M_memWrite,
    input  o_WB_memtoReg, o_WB_regWrite,
    input  o_pc_plus4, o_rs_data, o_rt_data, o_imm_ext, o_rs, o_rt, o_rd, o_funct,
    input  o_halt, o_load_use_stall, o_bubble_count
  );

  modport slave (
    input  i_valid, i_stall, i_flush, i_halt,
    input  i_EX_ALUOp, i_EX_ALUSrc, i_EX_regDst, i_M_branch, i_M_memRead, i_M_memWrite,
    input  i_WB_memtoReg, i_WB_regWrite,
    input  i_pc_plus4, i_rs_data, i_rt_data, i_imm_ext, i_rs, i_rt, i_rd, i_funct,
    output o_valid,
    output o_EX_ALUOp, o_EX_ALUSrc, o_EX_regDst, o_M_branch, o_M_memRead, o_M_memWrite,
    output o_WB_memtoReg, o_WB_regWrite,
    output o_pc_plus4, o_rs_data, o_rt_data, o_imm_ext, o_rs, o_rt, o_rd, o_funct,
    output o_halt, o_load_use_stall, o_bubble_count
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures the decoded instruction, detects load-use hazards,
// inserts bubbles on hazard/flush/idle, freezes on debug stall, and latches a sticky halt.
module id_ex_stage_reg #(
  parameter int unsigned N_BITS      = 32,
  parameter int unsigned N_BITS_REG  = 5,
  parameter int unsigned N_BITS_FUNC = 6,
  parameter int unsigned N_BITS_CNT  = 16
) (
  input logic              i_clk,
  input logic              i_reset,
  id_ex_stage_reg_if.slave bus
);

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] branch;
    logic       mem_read;
    logic       mem_write;
    logic       memto_reg;
    logic       reg_write;
  } ctrl_t;

  typedef struct packed {
    logic                   valid;
    ctrl_t                  ctrl;
    logic [N_BITS-1:0]      pc_plus4;
    logic [N_BITS-1:0]      rs_data;
    logic [N_BITS-1:0]      rt_data;
    logic [N_BITS-1:0]      imm_ext;
    logic [N_BITS_REG-1:0]  rs;
    logic [N_BITS_REG-1:0]  rt;
    logic [N_BITS_REG-1:0]  rd;
    logic [N_BITS_FUNC-1:0] funct;
  } stage_t;

  stage_t                stage_q, stage_d;
  logic                  halt_q, halt_d;
  logic [N_BITS_CNT-1:0] cnt_q, cnt_d;
  logic                  count_bubble;
  logic                  load_use;

  // Hazard only against a valid load held in EX whose destination is a real register.
  always_comb begin
    load_use = ~i_reset & stage_q.valid & stage_q.ctrl.mem_read & bus.i_valid & ~halt_q &
               (stage_q.rt != '0) & ((stage_q.rt == bus.i_rs) | (stage_q.rt == bus.i_rt));
  end

  always_comb begin
    stage_d      = stage_q;
    halt_d       = halt_q;
    cnt_d        = cnt_q;
    count_bubble = 1'b0;

    if (i_reset) begin
      stage_d = '0;
      halt_d  = 1'b0;
      cnt_d   = '0;
    end else if (bus.i_stall) begin
      // Debug freeze: everything holds.
    end else if (halt_q) begin
      stage_d = '0;
    end else if (bus.i_flush || load_use) begin
      stage_d      = '0;
      count_bubble = 1'b1;
    end else if (!bus.i_valid) begin
      stage_d = '0;
    end else begin
      stage_d.valid          = 1'b1;
      stage_d.ctrl.alu_op    = bus.i_EX_ALUOp;
      stage_d.ctrl.alu_src   = bus.i_EX_ALUSrc;
      stage_d.ctrl.reg_dst   = bus.i_EX_regDst;
      stage_d.ctrl.branch    = bus.i_M_branch;
      stage_d.ctrl.mem_read  = bus.i_M_memRead;
      stage_d.ctrl.mem_write = bus.i_M_memWrite;
      stage_d.ctrl.memto_reg = bus.i_WB_memtoReg;
      stage_d.ctrl.reg_write = bus.i_WB_regWrite;
      stage_d.pc_plus4       = bus.i_pc_plus4;
      stage_d.rs_data        = bus.i_rs_data;
      stage_d.rt_data        = bus.i_rt_data;
      stage_d.imm_ext        = bus.i_imm_ext;
      stage_d.rs             = bus.i_rs;
      stage_d.rt             = bus.i_rt;
      stage_d.rd             = bus.i_rd;
      stage_d.funct          = bus.i_funct;
      if (bus.i_halt) begin
        // HALT reaches EX as a valid slot but must not touch memory or registers.
        halt_d       = 1'b1;
        stage_d.ctrl = '0;
      end
    end

    if (count_bubble && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    stage_q <= stage_d;
    halt_q  <= halt_d;
    cnt_q   <= cnt_d;
  end

  always_comb begin
    bus.o_valid          = stage_q.valid;
    bus.o_EX_ALUOp       = stage_q.ctrl.alu_op;
    bus.o_EX_ALUSrc      = stage_q.ctrl.alu_src;
    bus.o_EX_regDst      = stage_q.ctrl.reg_dst;
    bus.o_M_branch       = stage_q.ctrl.branch;
    bus.o_M_memRead      = stage_q.ctrl.mem_read;
    bus.o_M_memWrite     = stage_q.ctrl.mem_write;
    bus.o_WB_memtoReg    = stage_q.ctrl.memto_reg;
    bus.o_WB_regWrite    = stage_q.ctrl.reg_write;
    bus.o_pc_plus4       = stage_q.pc_plus4;
    bus.o_rs_data        = stage_q.rs_data;
    bus.o_rt_data        = stage_q.rt_data;
    bus.o_imm_ext        = stage_q.imm_ext;
    bus.o_rs             = stage_q.rs;
    bus.o_rt             = stage_q.rt;
    bus.o_rd             = stage_q.rd;
    bus.o_funct          = stage_q.funct;
    bus.o_halt           = halt_q;
    bus.o_load_use_stall = load_use;
    bus.o_bubble_count   = cnt_q;
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed vector table, hand-written freeze/reset
// sequences, randomized traffic against a slot-level reference model, and counter saturation.
module tb_id_ex_stage_reg;
  localparam int unsigned NB = 32;
  localparam int unsigned NR = 5;
  localparam int unsigned NF = 6;
  localparam int unsigned NC = 16;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  id_ex_stage_reg_if #(.N_BITS(NB), .N_BITS_REG(NR), .N_BITS_FUNC(NF), .N_BITS_CNT(NC)) bus ();
  id_ex_stage_reg_if #(.N_BITS(NB), .N_BITS_REG(NR), .N_BITS_FUNC(NF), .N_BITS_CNT(2)) bus2 ();

  id_ex_stage_reg #(.N_BITS(NB), .N_BITS_REG(NR), .N_BITS_FUNC(NF), .N_BITS_CNT(NC)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus.slave)
  );

  id_ex_stage_reg #(.N_BITS(NB), .N_BITS_REG(NR), .N_BITS_FUNC(NF), .N_BITS_CNT(2)) dut2 (
    .i_clk  (clk),
    .i_reset(rst2),
    .bus    (bus2.slave)
  );

  typedef struct packed {
    logic        reset, valid, stall, flush, halt;
    logic [1:0]  alu_op;
    logic        alu_src, reg_dst;
    logic [1:0]  branch;
    logic        mem_read, mem_write, memto_reg, reg_write;
    logic [31:0] pc4, rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
  } in_t;

  typedef struct {
    in_t        stim;
    logic       e_stall;
    logic       e_valid;
    logic       e_halt;
    int         e_cnt;
    logic [4:0] e_rd;
    logic       e_mr;
    logic       e_rdst;
  } vec_t;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: what EX currently holds, as a whole instruction record.
  logic m_valid = 1'b0;
  logic m_halt  = 1'b0;
  int   m_cnt   = 0;
  in_t  m_cap   = '0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_stall(input in_t x);
    return !x.reset && m_valid && m_cap.mem_read && x.valid && !m_halt && (m_cap.rt != 0) &&
           ((m_cap.rt == x.rs) || (m_cap.rt == x.rt));
  endfunction

  task automatic model_step(input in_t x, input int cmax);
    logic hz;
    hz = model_stall(x);
    if (x.reset) begin
      m_cap = '0; m_valid = 1'b0; m_halt = 1'b0; m_cnt = 0;
    end else if (!x.stall) begin
      if (m_halt || x.flush || hz || !x.valid) begin
        m_cap   = '0;
        m_valid = 1'b0;
        if (!m_halt && (x.flush || hz)) m_cnt = (m_cnt + 1 > cmax) ? cmax : m_cnt + 1;
      end else begin
        m_cap = x;
        m_cap.reset = 1'b0; m_cap.valid = 1'b0; m_cap.stall = 1'b0;
        m_cap.flush = 1'b0; m_cap.halt = 1'b0;
        m_valid = 1'b1;
        if (x.halt) begin
          m_halt = 1'b1;
          m_cap.alu_op = '0; m_cap.alu_src = 1'b0; m_cap.reg_dst = 1'b0; m_cap.branch = '0;
          m_cap.mem_read = 1'b0; m_cap.mem_write = 1'b0; m_cap.memto_reg = 1'b0;
          m_cap.reg_write = 1'b0;
        end
      end
    end
  endtask

  task automatic drive(input in_t x);
    rst               = x.reset;
    bus.i_valid       = x.valid;
    bus.i_stall       = x.stall;
    bus.i_flush       = x.flush;
    bus.i_halt        = x.halt;
    bus.i_EX_ALUOp    = x.alu_op;
    bus.i_EX_ALUSrc   = x.alu_src;
    bus.i_EX_regDst   = x.reg_dst;
    bus.i_M_branch    = x.branch;
    bus.i_M_memRead   = x.mem_read;
    bus.i_M_memWrite  = x.mem_write;
    bus.i_WB_memtoReg = x.memto_reg;
    bus.i_WB_regWrite = x.reg_write;
    bus.i_pc_plus4    = x.pc4;
    bus.i_rs_data     = x.rs_data;
    bus.i_rt_data     = x.rt_data;
    bus.i_imm_ext     = x.imm;
    bus.i_rs          = x.rs;
    bus.i_rt          = x.rt;
    bus.i_rd          = x.rd;
    bus.i_funct       = x.funct;
  endtask

  task automatic get_out(output in_t o);
    o           = '0;
    o.alu_op    = bus.o_EX_ALUOp;
    o.alu_src   = bus.o_EX_ALUSrc;
    o.reg_dst   = bus.o_EX_regDst;
    o.branch    = bus.o_M_branch;
    o.mem_read  = bus.o_M_memRead;
    o.mem_write = bus.o_M_memWrite;
    o.memto_reg = bus.o_WB_memtoReg;
    o.reg_write = bus.o_WB_regWrite;
    o.pc4       = bus.o_pc_plus4;
    o.rs_data   = bus.o_rs_data;
    o.rt_data   = bus.o_rt_data;
    o.imm       = bus.o_imm_ext;
    o.rs        = bus.o_rs;
    o.rt        = bus.o_rt;
    o.rd        = bus.o_rd;
    o.funct     = bus.o_funct;
  endtask

  // Drive, sample the combinational stall, clock once, advance model, settle.
  task automatic cycle(input in_t x, output logic dut_st, output logic mod_st);
    drive(x);
    #1;
    dut_st = bus.o_load_use_stall;
    mod_st = model_stall(x);
    @(posedge clk);
    model_step(x, 65535);
    #1;
  endtask

  task automatic check_model(input string tag);
    in_t o;
    get_out(o);
    check({tag, "_payload"}, o, m_cap);
    check({tag, "_valid"}, bus.o_valid, m_valid);
    check({tag, "_halt"}, bus.o_halt, m_halt);
    check({tag, "_cnt"}, bus.o_bubble_count, m_cnt);
  endtask

  function automatic in_t rtype(input int rs, input int rt, input int rd);
    in_t x = '0;
    x.valid = 1'b1; x.reg_dst = 1'b1; x.reg_write = 1'b1; x.alu_op = 2'd2;
    x.rs = rs[4:0]; x.rt = rt[4:0]; x.rd = rd[4:0]; x.funct = 6'h20;
    x.pc4 = 32'h100 + rd; x.rs_data = 32'hA0 + rs; x.rt_data = 32'hB0 + rt; x.imm = 32'h20;
    return x;
  endfunction

  function automatic in_t lw(input int rs, input int rt);
    in_t x = '0;
    x.valid = 1'b1; x.alu_src = 1'b1; x.mem_read = 1'b1; x.memto_reg = 1'b1;
    x.reg_write = 1'b1; x.rs = rs[4:0]; x.rt = rt[4:0]; x.imm = 32'h4; x.pc4 = 32'h200;
    x.rs_data = 32'h1000;
    return x;
  endfunction

  function automatic vec_t mk(input in_t s, input logic st, input logic v, input logic h,
                              input int c, input int rd, input logic mr, input logic rdst);
    vec_t t;
    t.stim = s; t.e_stall = st; t.e_valid = v; t.e_halt = h; t.e_cnt = c;
    t.e_rd = rd[4:0]; t.e_mr = mr; t.e_rdst = rdst;
    return t;
  endfunction

  initial begin
    vec_t tv[14];
    in_t  x;
    in_t  o;
    logic ds, ms;

    rst2 = 1'b1;
    bus2.i_valid = 1'b0; bus2.i_stall = 1'b0; bus2.i_flush = 1'b0; bus2.i_halt = 1'b0;
    bus2.i_EX_ALUOp = '0; bus2.i_EX_ALUSrc = 1'b0; bus2.i_EX_regDst = 1'b0;
    bus2.i_M_branch = '0; bus2.i_M_memRead = 1'b0; bus2.i_M_memWrite = 1'b0;
    bus2.i_WB_memtoReg = 1'b0; bus2.i_WB_regWrite = 1'b0; bus2.i_pc_plus4 = '0;
    bus2.i_rs_data = '0; bus2.i_rt_data = '0; bus2.i_imm_ext = '0;
    bus2.i_rs = '0; bus2.i_rt = '0; bus2.i_rd = '0; bus2.i_funct = '0;

    x = '0; x.reset = 1'b1;
    tv[0]  = mk(x, 0, 0, 0, 0, 0, 0, 0);
    tv[1]  = mk(rtype(3, 4, 5), 0, 1, 0, 0, 5, 0, 1);
    tv[2]  = mk(lw(2, 8), 0, 1, 0, 0, 0, 1, 0);
    tv[3]  = mk(rtype(8, 9, 10), 1, 0, 0, 1, 0, 0, 0);
    tv[4]  = mk(rtype(8, 9, 10), 0, 1, 0, 1, 10, 0, 1);
    tv[5]  = mk(lw(1, 0), 0, 1, 0, 1, 0, 1, 0);
    tv[6]  = mk(rtype(0, 0, 11), 0, 1, 0, 1, 11, 0, 1);
    tv[7]  = mk(lw(1, 7), 0, 1, 0, 1, 0, 1, 0);
    x = rtype(7, 2, 14); x.flush = 1'b1;
    tv[8]  = mk(x, 1, 0, 0, 2, 0, 0, 0);
    x = rtype(3, 3, 3); x.valid = 1'b0;
    tv[9]  = mk(x, 0, 0, 0, 2, 0, 0, 0);
    x = rtype(1, 2, 12); x.halt = 1'b1;
    tv[10] = mk(x, 0, 1, 1, 2, 12, 0, 0);
    tv[11] = mk(rtype(1, 2, 13), 0, 0, 1, 2, 0, 0, 0);
    x = rtype(1, 2, 13); x.flush = 1'b1;
    tv[12] = mk(x, 0, 0, 1, 2, 0, 0, 0);
    x = rtype(1, 2, 13); x.reset = 1'b1;
    tv[13] = mk(x, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      cycle(tv[i].stim, ds, ms);
      check($sformatf("vec%0d_stall", i), ds, tv[i].e_stall);
      check($sformatf("vec%0d_valid", i), bus.o_valid, tv[i].e_valid);
      check($sformatf("vec%0d_halt", i), bus.o_halt, tv[i].e_halt);
      check($sformatf("vec%0d_cnt", i), bus.o_bubble_count, tv[i].e_cnt);
      check($sformatf("vec%0d_rd", i), bus.o_rd, tv[i].e_rd);
      check($sformatf("vec%0d_memread", i), bus.o_M_memRead, tv[i].e_mr);
      check($sformatf("vec%0d_regdst", i), bus.o_EX_regDst, tv[i].e_rdst);
      if (bus.o_valid === 1'b0) begin
        get_out(o);
        check($sformatf("vec%0d_bubble_zero", i), o, 164'd0);
      end
    end

    // Debug freeze with a pending flush: nothing moves; the flush lands on release.
    cycle(rtype(3, 4, 5), ds, ms);
    for (int i = 0; i < 3; i++) begin
      x = rtype(4, 4, 6); x.stall = 1'b1; x.flush = 1'b1;
      cycle(x, ds, ms);
      check($sformatf("freeze%0d_valid", i), bus.o_valid, 1'b1);
      check($sformatf("freeze%0d_rd", i), bus.o_rd, 5'd5);
      check($sformatf("freeze%0d_cnt", i), bus.o_bubble_count, 0);
    end
    x = rtype(4, 4, 6); x.flush = 1'b1;
    cycle(x, ds, ms);
    check("release_valid", bus.o_valid, 1'b0);
    check("release_cnt", bus.o_bubble_count, 1);

    // Hazard raised during a freeze, then reset arrives mid-stall.
    cycle(lw(1, 9), ds, ms);
    x = rtype(9, 0, 1); x.stall = 1'b1;
    cycle(x, ds, ms);
    check("frozen_hazard_stall", ds, 1'b1);
    check("frozen_hazard_memread", bus.o_M_memRead, 1'b1);
    x.reset = 1'b1;
    cycle(x, ds, ms);
    check("reset_drops_stall", ds, 1'b0);
    check("reset_mid_stall_valid", bus.o_valid, 1'b0);
    check("reset_mid_stall_cnt", bus.o_bubble_count, 0);

    // Randomized traffic against the model; small register range makes hazards common.
    for (int i = 0; i < 400; i++) begin
      x           = '0;
      x.reset     = ($urandom_range(99) < 3);
      x.valid     = ($urandom_range(99) < 80);
      x.stall     = ($urandom_range(99) < 10);
      x.flush     = ($urandom_range(99) < 10);
      x.halt      = ($urandom_range(99) < 2);
      x.alu_op    = 2'($urandom);
      x.alu_src   = 1'($urandom);
      x.reg_dst   = 1'($urandom);
      x.branch    = 2'($urandom);
      x.mem_read  = ($urandom_range(99) < 40);
      x.mem_write = 1'($urandom);
      x.memto_reg = 1'($urandom);
      x.reg_write = 1'($urandom);
      x.pc4       = $urandom;
      x.rs_data   = $urandom;
      x.rt_data   = $urandom;
      x.imm       = $urandom;
      x.rs        = 5'($urandom_range(3));
      x.rt        = 5'($urandom_range(3));
      x.rd        = 5'($urandom);
      x.funct     = 6'($urandom);
      cycle(x, ds, ms);
      check($sformatf("rnd%0d_stall", i), ds, ms);
      check_model($sformatf("rnd%0d", i));
    end

    // Two-bit counter saturates at 3 with no wrap.
    rst2 = 1'b1;
    @(posedge clk); #1;
    check("sat_reset_cnt", bus2.o_bubble_count, 0);
    rst2 = 1'b0; bus2.i_valid = 1'b1; bus2.i_flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("sat_flush%0d_cnt", i), bus2.o_bubble_count, (i + 1 > 3) ? 3 : i + 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
